multicycle_control_unit: RTL and testbench

Multi-cycle RV32I control FSM for the next-generation core, which shares one memory port between fetch and data. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives datapath enables and muxes from the current state and the instruction register. It holds on a memory ready/request handshake, traps on illegal encodings and on memory timeouts, and decodes the full RV32I ALU set including xor and shift-immediates.

---
 rtl/multicycle_control_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with one memory port shared by fetch and data.
// Walks each instruction through fetch/decode/execute/memory/write-back.
// Memory accesses hold on a ready handshake and are guarded by a watchdog.
// Bad encodings and memory timeouts enter TRAP, which records why.
module multicycle_control_unit #(
   parameter int ALU_CTRL_W     = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit TRAP_HALT      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           instr,
   input  logic                  mem_ready,
   input  logic                  br_taken,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  adr_sel,
   output logic                  ir_write,
   output logic                  pc_write,
   output logic [1:0]            pc_src,
   output logic                  reg_write,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            wb_sel,
   output logic [2:0]            imm_sel,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  illegal_instr,
   output logic                  mem_timeout,
   output logic                  busy
);

   typedef enum logic [3:0] {
      ST_RESET,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_ALU_WB,
      ST_MEM_ADDR,
      ST_MEM_ACCESS,
      ST_MEM_WB,
      ST_BRANCH,
      ST_JUMP,
      ST_TRAP
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SRL  = 4'd3;
   localparam logic [3:0] ALU_SRA  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_XOR  = 4'd9;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   // Watchdog counts stalled cycles; it never needs to hold TIMEOUT_CYCLES itself
   // because the last stalled cycle is detected while the count is one below it.
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam bit WD_ENABLE = (TIMEOUT_CYCLES != 0);

   state_t state;
   state_t next_state;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            instr_legal;
   logic [3:0]      exec_alu;
   logic [3:0]      alu_code;
   logic            req_state;
   logic            wd_expire;
   logic [WD_W-1:0] wd_cnt;
   logic            cause_illegal;
   logic            cause_timeout;
   logic            set_illegal;
   logic            set_timeout;
   logic            unused_instr_bits;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Register and immediate fields are consumed by the datapath, not by control.
   assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

   // The states that drive mem_req; kept separate so the watchdog does not depend on the output block.
   assign req_state = (state == ST_FETCH) || (state == ST_MEM_ACCESS);

   assign wd_expire = WD_ENABLE && req_state && !mem_ready && (wd_cnt == WD_LAST);

   // Encoding legality check for the RV32I subset this core implements.
   always_comb begin
      instr_legal = 1'b0;
      case (opcode)
         OP_R: begin
            instr_legal = (funct7 == 7'h00) ||
                          ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         OP_IMM: begin
            if (funct3 == 3'b001) begin
               instr_legal = (funct7 == 7'h00);
            end else if (funct3 == 3'b101) begin
               instr_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            end else begin
               instr_legal = 1'b1;
            end
         end
         OP_LUI, OP_AUIPC, OP_JAL: instr_legal = 1'b1;
         OP_LOAD, OP_STORE:        instr_legal = (funct3 == 3'b010);
         OP_BRANCH:                instr_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
         OP_JALR:                  instr_legal = (funct3 == 3'b000);
         default:                  instr_legal = 1'b0;
      endcase
   end

   // ALU operation for R-type and OP-IMM; instr[30] picks sub/sra, and OP-IMM has no subtract.
   always_comb begin
      exec_alu = ALU_ADD;
      if ((opcode == OP_R) || (opcode == OP_IMM)) begin
         case (funct3)
            3'b000:  exec_alu = ((opcode == OP_R) && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  exec_alu = ALU_SLL;
            3'b010:  exec_alu = ALU_SLT;
            3'b011:  exec_alu = ALU_SLTU;
            3'b100:  exec_alu = ALU_XOR;
            3'b101:  exec_alu = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  exec_alu = ALU_OR;
            default: exec_alu = ALU_AND;
         endcase
      end
   end

   // State register; reset drops any in-flight access and restarts from RESET.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RESET;
      end else begin
         state <= next_state;
      end
   end

   // Watchdog: counts consecutive stalled request cycles, clears on completion or state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (req_state && !mem_ready && (next_state == state)) begin
         wd_cnt <= wd_cnt + 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end

   // Trap cause register: captured on TRAP entry, cleared when TRAP is left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cause_illegal <= 1'b0;
         cause_timeout <= 1'b0;
      end else if (state == ST_TRAP) begin
         if (next_state != ST_TRAP) begin
            cause_illegal <= 1'b0;
            cause_timeout <= 1'b0;
         end
      end else if (next_state == ST_TRAP) begin
         cause_illegal <= set_illegal;
         cause_timeout <= set_timeout;
      end
   end

   // Next-state and datapath controls from the current state and instruction.
   always_comb begin
      next_state    = state;
      set_illegal   = 1'b0;
      set_timeout   = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      adr_sel       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      wb_sel        = 2'b00;
      imm_sel       = IMM_I;
      alu_code      = ALU_ADD;
      illegal_instr = 1'b0;
      mem_timeout   = 1'b0;
      busy          = 1'b1;

      case (state)
         ST_RESET: begin
            busy       = 1'b0;
            next_state = ST_FETCH;
         end

         ST_FETCH: begin
            mem_req   = 1'b1;
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            alu_code  = ALU_ADD;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               pc_src     = 2'b00;
               next_state = ST_DECODE;
            end else if (wd_expire) begin
               set_timeout = 1'b1;
               next_state  = ST_TRAP;
            end
         end

         ST_DECODE: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_code  = ALU_ADD;
            if (opcode == OP_BRANCH) begin
               imm_sel = IMM_B;
            end else if (opcode == OP_JAL) begin
               imm_sel = IMM_J;
            end else begin
               imm_sel = IMM_I;
            end
            if (!instr_legal) begin
               set_illegal = 1'b1;
               next_state  = ST_TRAP;
            end else begin
               case (opcode)
                  OP_R, OP_IMM, OP_LUI, OP_AUIPC: next_state = ST_EXEC;
                  OP_LOAD, OP_STORE:              next_state = ST_MEM_ADDR;
                  OP_BRANCH:                      next_state = ST_BRANCH;
                  default:                        next_state = ST_JUMP;
               endcase
            end
         end

         ST_EXEC: begin
            case (opcode)
               OP_R: begin
                  alu_src_a = 2'b00;
                  alu_src_b = 2'b00;
                  alu_code  = exec_alu;
               end
               OP_IMM: begin
                  alu_src_a = 2'b00;
                  alu_src_b = 2'b01;
                  imm_sel   = IMM_I;
                  alu_code  = exec_alu;
               end
               OP_LUI: begin
                  alu_src_a = 2'b11;
                  alu_src_b = 2'b01;
                  imm_sel   = IMM_U;
               end
               default: begin
                  alu_src_a = 2'b10;
                  alu_src_b = 2'b01;
                  imm_sel   = IMM_U;
               end
            endcase
            next_state = ST_ALU_WB;
         end

         ST_ALU_WB: begin
            reg_write  = 1'b1;
            wb_sel     = 2'b00;
            next_state = ST_FETCH;
         end

         ST_MEM_ADDR: begin
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b01;
            imm_sel    = (opcode == OP_STORE) ? IMM_S : IMM_I;
            alu_code   = ALU_ADD;
            next_state = ST_MEM_ACCESS;
         end

         ST_MEM_ACCESS: begin
            mem_req = 1'b1;
            adr_sel = 1'b1;
            mem_we  = (opcode == OP_STORE);
            if (mem_ready) begin
               next_state = (opcode == OP_STORE) ? ST_FETCH : ST_MEM_WB;
            end else if (wd_expire) begin
               set_timeout = 1'b1;
               next_state  = ST_TRAP;
            end
         end

         ST_MEM_WB: begin
            reg_write  = 1'b1;
            wb_sel     = 2'b01;
            next_state = ST_FETCH;
         end

         ST_BRANCH: begin
            pc_write   = br_taken;
            pc_src     = 2'b01;
            next_state = ST_FETCH;
         end

         ST_JUMP: begin
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            pc_write  = 1'b1;
            if (opcode == OP_JALR) begin
               alu_src_a = 2'b00;
               alu_src_b = 2'b01;
               imm_sel   = IMM_I;
               alu_code  = ALU_ADD;
               pc_src    = 2'b10;
            end else begin
               pc_src    = 2'b01;
            end
            next_state = ST_FETCH;
         end

         ST_TRAP: begin
            illegal_instr = cause_illegal;
            mem_timeout   = cause_timeout;
            if (TRAP_HALT) begin
               busy       = 1'b0;
               next_state = ST_TRAP;
            end else begin
               next_state = ST_FETCH;
            end
         end

         default: begin
            busy       = 1'b0;
            next_state = ST_RESET;
         end
      endcase
   end

   assign alu_ctrl = ALU_CTRL_W'(alu_code);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: per-cycle expected output vectors from a
// table, pushed to a scoreboard as inputs are driven and popped when sampled.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       adr_sel;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] wb_sel;
      logic [2:0] imm_sel;
      logic [3:0] alu_ctrl;
      logic       illegal_instr;
      logic       mem_timeout;
      logic       busy;
   } outs_t;

   typedef struct {
      logic [31:0] instr;
      logic        ready;
      logic        taken;
      outs_t       exp;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        mem_ready;
   logic        br_taken;

   logic       r_mem_req, r_mem_we, r_adr_sel, r_ir_write, r_pc_write, r_reg_write;
   logic [1:0] r_pc_src, r_alu_src_a, r_alu_src_b, r_wb_sel;
   logic [2:0] r_imm_sel;
   logic [3:0] r_alu_ctrl;
   logic       r_illegal_instr, r_mem_timeout, r_busy;

   logic       h_mem_req, h_mem_we, h_adr_sel, h_ir_write, h_pc_write, h_reg_write;
   logic [1:0] h_pc_src, h_alu_src_a, h_alu_src_b, h_wb_sel;
   logic [2:0] h_imm_sel;
   logic [3:0] h_alu_ctrl;
   logic       h_illegal_instr, h_mem_timeout, h_busy;

   outs_t act_r;
   outs_t act_h;

   vec_t  vecs[$];
   string names[$];
   outs_t exp_q[$];
   string name_q[$];

   int total;
   int bad;

   // Resuming variant: one cycle in TRAP then back to FETCH.
   multicycle_control_unit #(
      .ALU_CTRL_W(4), .TIMEOUT_CYCLES(4), .TRAP_HALT(1'b0)
   ) dut_r (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
      .mem_req(r_mem_req), .mem_we(r_mem_we), .adr_sel(r_adr_sel), .ir_write(r_ir_write),
      .pc_write(r_pc_write), .pc_src(r_pc_src), .reg_write(r_reg_write),
      .alu_src_a(r_alu_src_a), .alu_src_b(r_alu_src_b), .wb_sel(r_wb_sel),
      .imm_sel(r_imm_sel), .alu_ctrl(r_alu_ctrl), .illegal_instr(r_illegal_instr),
      .mem_timeout(r_mem_timeout), .busy(r_busy)
   );

   // Halting variant: stays in TRAP until reset.
   multicycle_control_unit #(
      .ALU_CTRL_W(4), .TIMEOUT_CYCLES(4), .TRAP_HALT(1'b1)
   ) dut_h (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
      .mem_req(h_mem_req), .mem_we(h_mem_we), .adr_sel(h_adr_sel), .ir_write(h_ir_write),
      .pc_write(h_pc_write), .pc_src(h_pc_src), .reg_write(h_reg_write),
      .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .wb_sel(h_wb_sel),
      .imm_sel(h_imm_sel), .alu_ctrl(h_alu_ctrl), .illegal_instr(h_illegal_instr),
      .mem_timeout(h_mem_timeout), .busy(h_busy)
   );

   assign act_r = {r_mem_req, r_mem_we, r_adr_sel, r_ir_write, r_pc_write, r_pc_src,
                   r_reg_write, r_alu_src_a, r_alu_src_b, r_wb_sel, r_imm_sel, r_alu_ctrl,
                   r_illegal_instr, r_mem_timeout, r_busy};
   assign act_h = {h_mem_req, h_mem_we, h_adr_sel, h_ir_write, h_pc_write, h_pc_src,
                   h_reg_write, h_alu_src_a, h_alu_src_b, h_wb_sel, h_imm_sel, h_alu_ctrl,
                   h_illegal_instr, h_mem_timeout, h_busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs per state, written from the state descriptions.
   function automatic outs_t o_fetch(input logic rdy);
      outs_t e;
      e = '0;
      e.mem_req = 1'b1; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
      e.ir_write = rdy; e.pc_write = rdy; e.busy = 1'b1;
      return e;
   endfunction

   function automatic outs_t o_decode(input logic [2:0] imm);
      outs_t e;
      e = '0;
      e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.imm_sel = imm; e.busy = 1'b1;
      return e;
   endfunction

   function automatic outs_t o_exec(input logic [1:0] a, input logic [1:0] b,
                                    input logic [2:0] imm, input logic [3:0] alu);
      outs_t e;
      e = '0;
      e.alu_src_a = a; e.alu_src_b = b; e.imm_sel = imm; e.alu_ctrl = alu; e.busy = 1'b1;
      return e;
   endfunction

   function automatic outs_t o_wb(input logic [1:0] sel);
      outs_t e;
      e = '0;
      e.reg_write = 1'b1; e.wb_sel = sel; e.busy = 1'b1;
      return e;
   endfunction

   function automatic outs_t o_mem_access(input logic we);
      outs_t e;
      e = '0;
      e.mem_req = 1'b1; e.adr_sel = 1'b1; e.mem_we = we; e.busy = 1'b1;
      return e;
   endfunction

   function automatic outs_t o_branch(input logic taken);
      outs_t e;
      e = '0;
      e.pc_write = taken; e.pc_src = 2'b01; e.busy = 1'b1;
      return e;
   endfunction

   function automatic outs_t o_jump(input logic is_jalr);
      outs_t e;
      e = '0;
      e.reg_write = 1'b1; e.wb_sel = 2'b10; e.pc_write = 1'b1; e.busy = 1'b1;
      if (is_jalr) begin
         e.alu_src_b = 2'b01;
         e.pc_src = 2'b10;
      end else begin
         e.pc_src = 2'b01;
      end
      return e;
   endfunction

   function automatic outs_t o_trap(input logic ill, input logic tmo, input logic bsy);
      outs_t e;
      e = '0;
      e.illegal_instr = ill; e.mem_timeout = tmo; e.busy = bsy;
      return e;
   endfunction

   task automatic addRow(input logic [31:0] ins, input logic rdy, input logic tk,
                         input outs_t e, input string nm);
      vec_t v;
      v.instr = ins; v.ready = rdy; v.taken = tk; v.exp = e;
      vecs.push_back(v);
      names.push_back(nm);
   endtask

   task automatic seqAlu(input logic [31:0] ins, input logic [1:0] a, input logic [1:0] b,
                         input logic [2:0] imm, input logic [3:0] alu, input string nm);
      addRow(ins, 1'b1, 1'b0, o_fetch(1'b1),      {nm, "/fetch"});
      addRow(ins, 1'b1, 1'b0, o_decode(3'b000),   {nm, "/decode"});
      addRow(ins, 1'b1, 1'b0, o_exec(a, b, imm, alu), {nm, "/exec"});
      addRow(ins, 1'b1, 1'b0, o_wb(2'b00),        {nm, "/alu_wb"});
   endtask

   task automatic applyStimulus(input logic [31:0] ins, input logic rdy, input logic tk);
      @(negedge clk);
      instr = ins;
      mem_ready = rdy;
      br_taken = tk;
   endtask

   task automatic expectOut(input outs_t e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic checkOutput(input bit use_h);
      outs_t got;
      outs_t want;
      string nm;
      got = use_h ? act_h : act_r;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_empty: got %h required <none>", got);
      end else begin
         want = exp_q.pop_front();
         nm = name_q.pop_front();
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s (%s): got %h required %h", nm, use_h ? "halt" : "resume", got, want);
         end
      end
   endtask

   // Reset both DUTs, check outputs during reset and in the RESET state after release.
   task automatic doReset(input string nm);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      expectOut('0, {nm, "/in_reset"}); checkOutput(1'b0);
      expectOut('0, {nm, "/in_reset"}); checkOutput(1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      expectOut('0, {nm, "/reset_state"}); checkOutput(1'b0);
      expectOut('0, {nm, "/reset_state"}); checkOutput(1'b1);
   endtask

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_SUB   = 32'h402081B3;
   localparam logic [31:0] I_XOR   = 32'h0020C1B3;
   localparam logic [31:0] I_SRAI  = 32'h4030D093;
   localparam logic [31:0] I_SLLI  = 32'h00209093;
   localparam logic [31:0] I_LUI   = 32'h123452B7;
   localparam logic [31:0] I_AUIPC = 32'h00001297;
   localparam logic [31:0] I_LW    = 32'h0040A103;
   localparam logic [31:0] I_SW    = 32'h0020A423;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_JAL   = 32'h010000EF;
   localparam logic [31:0] I_JALR  = 32'h000080E7;
   localparam logic [31:0] I_BADOP = 32'h0000007F;
   localparam logic [31:0] I_BADF7 = 32'h022081B3;

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      instr = '0;
      mem_ready = 1'b0;
      br_taken = 1'b0;

      // Table of per-cycle vectors for the resuming DUT.
      seqAlu(I_ADDI,  2'b00, 2'b01, 3'b000, 4'd0, "addi");
      seqAlu(I_SUB,   2'b00, 2'b00, 3'b000, 4'd1, "sub");
      seqAlu(I_XOR,   2'b00, 2'b00, 3'b000, 4'd9, "xor");
      seqAlu(I_SRAI,  2'b00, 2'b01, 3'b000, 4'd4, "srai");
      addRow(I_SLLI, 1'b0, 1'b0, o_fetch(1'b0), "slli/fetch_wait");
      seqAlu(I_SLLI,  2'b00, 2'b01, 3'b000, 4'd2, "slli");
      seqAlu(I_LUI,   2'b11, 2'b01, 3'b011, 4'd0, "lui");
      seqAlu(I_AUIPC, 2'b10, 2'b01, 3'b011, 4'd0, "auipc");

      addRow(I_LW, 1'b1, 1'b0, o_fetch(1'b1),                   "lw/fetch");
      addRow(I_LW, 1'b1, 1'b0, o_decode(3'b000),                "lw/decode");
      addRow(I_LW, 1'b1, 1'b0, o_exec(2'b00, 2'b01, 3'b000, 4'd0), "lw/mem_addr");
      addRow(I_LW, 1'b0, 1'b0, o_mem_access(1'b0),              "lw/wait1");
      addRow(I_LW, 1'b0, 1'b0, o_mem_access(1'b0),              "lw/wait2");
      addRow(I_LW, 1'b0, 1'b0, o_mem_access(1'b0),              "lw/wait3");
      addRow(I_LW, 1'b1, 1'b0, o_mem_access(1'b0),              "lw/access");
      addRow(I_LW, 1'b1, 1'b0, o_wb(2'b01),                     "lw/mem_wb");

      addRow(I_SW, 1'b1, 1'b0, o_fetch(1'b1),                   "sw/fetch");
      addRow(I_SW, 1'b1, 1'b0, o_decode(3'b000),                "sw/decode");
      addRow(I_SW, 1'b1, 1'b0, o_exec(2'b00, 2'b01, 3'b001, 4'd0), "sw/mem_addr");
      addRow(I_SW, 1'b1, 1'b0, o_mem_access(1'b1),              "sw/access");

      addRow(I_BEQ, 1'b1, 1'b1, o_fetch(1'b1),    "beq_t/fetch");
      addRow(I_BEQ, 1'b1, 1'b1, o_decode(3'b010), "beq_t/decode");
      addRow(I_BEQ, 1'b1, 1'b1, o_branch(1'b1),   "beq_t/branch");
      addRow(I_BEQ, 1'b1, 1'b0, o_fetch(1'b1),    "beq_n/fetch");
      addRow(I_BEQ, 1'b1, 1'b0, o_decode(3'b010), "beq_n/decode");
      addRow(I_BEQ, 1'b1, 1'b0, o_branch(1'b0),   "beq_n/branch");

      addRow(I_JAL, 1'b1, 1'b0, o_fetch(1'b1),    "jal/fetch");
      addRow(I_JAL, 1'b1, 1'b0, o_decode(3'b100), "jal/decode");
      addRow(I_JAL, 1'b1, 1'b0, o_jump(1'b0),     "jal/jump");
      addRow(I_JALR, 1'b1, 1'b0, o_fetch(1'b1),    "jalr/fetch");
      addRow(I_JALR, 1'b1, 1'b0, o_decode(3'b000), "jalr/decode");
      addRow(I_JALR, 1'b1, 1'b0, o_jump(1'b1),     "jalr/jump");

      addRow(I_BADOP, 1'b1, 1'b0, o_fetch(1'b1),             "badop/fetch");
      addRow(I_BADOP, 1'b1, 1'b0, o_decode(3'b000),          "badop/decode");
      addRow(I_BADOP, 1'b1, 1'b0, o_trap(1'b1, 1'b0, 1'b1),  "badop/trap");
      addRow(I_BADF7, 1'b1, 1'b0, o_fetch(1'b1),             "badf7/fetch");
      addRow(I_BADF7, 1'b1, 1'b0, o_decode(3'b000),          "badf7/decode");
      addRow(I_BADF7, 1'b1, 1'b0, o_trap(1'b1, 1'b0, 1'b1),  "badf7/trap");
      addRow(I_ADDI, 1'b0, 1'b0, o_fetch(1'b0),              "after_trap/fetch_clear");

      doReset("init");

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].instr, vecs[i].ready, vecs[i].taken);
         expectOut(vecs[i].exp, names[i]);
         #2;
         checkOutput(1'b0);
      end

      // Halting DUT has been parked in TRAP since the first bad opcode.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(I_ADDI, 1'b1, 1'b0);
         expectOut(o_trap(1'b1, 1'b0, 1'b0), "halt/illegal_hold");
         #2;
         checkOutput(1'b1);
      end

      // Watchdog: four stalled fetch cycles, then TRAP with mem_timeout.
      doReset("timeout");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(I_ADDI, 1'b0, 1'b0);
         expectOut(o_fetch(1'b0), "timeout/stall");
         #2;
         checkOutput(1'b0);
      end
      applyStimulus(I_ADDI, 1'b0, 1'b0);
      expectOut(o_trap(1'b0, 1'b1, 1'b1), "timeout/trap");
      expectOut(o_trap(1'b0, 1'b1, 1'b0), "timeout/trap");
      #2;
      checkOutput(1'b0);
      checkOutput(1'b1);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(I_ADDI, 1'b0, 1'b0);
         expectOut(o_fetch(1'b0), "timeout/refetch_stall");
         expectOut(o_trap(1'b0, 1'b1, 1'b0), "timeout/halt_hold");
         #2;
         checkOutput(1'b0);
         checkOutput(1'b1);
      end

      // Reset mid-wait forces RESET at once, then a clean instruction runs.
      doReset("midwait");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(I_ADDI, 1'b0, 1'b0);
         expectOut(o_fetch(1'b0), "post_reset/stall");
         #2;
         checkOutput(1'b0);
      end
      applyStimulus(I_ADDI, 1'b1, 1'b0);
      expectOut(o_fetch(1'b1), "post_reset/fetch");
      #2;
      checkOutput(1'b0);
      applyStimulus(I_ADDI, 1'b1, 1'b0);
      expectOut(o_decode(3'b000), "post_reset/decode");
      #2;
      checkOutput(1'b0);

      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_leftover: got %0d required 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
